// File: rtl/pixel_pkg.sv
// pixel_pkg
// Shared types and constants for the pixel write-back path:
//   rgb444_t      - 12-bit colour {R[11:8], G[7:4], B[3:0]}
//   fb_entry_t    - one framebuffer write {addr, data}, 32 bits wide
//   PALETTE       - block index to colour map; index MISS_BLOCK is background
//   SHADE_E_*     - exponent thresholds for depth shading
//   shade_color() - dims a colour by distance exponent
package pixel_pkg;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic [19:0] addr;
        rgb444_t     data;
    } fb_entry_t;

    localparam int FB_ADDR_W = 20;
    localparam int ENTRY_W   = 32;

    localparam logic [3:0] MISS_BLOCK = 4'd15;

    // Exponent thresholds: below LVL1 -> level 0, below LVL2 -> 1,
    // below LVL3 -> 2, otherwise 3.
    localparam logic [7:0] SHADE_E_LVL1 = 8'd130;
    localparam logic [7:0] SHADE_E_LVL2 = 8'd131;
    localparam logic [7:0] SHADE_E_LVL3 = 8'd132;

    localparam rgb444_t PALETTE [16] = '{
        12'hF00, 12'h0F0, 12'hFFF, 12'h00F,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h888,
        12'hF80, 12'h8F0, 12'h08F, 12'hF08,
        12'h80F, 12'h0F8, 12'h444, 12'h123
    };

    // Shift each channel right by a level derived from the float exponent.
    function automatic rgb444_t shade_color(input rgb444_t c, input logic [7:0] e);
        logic [1:0] lvl;
        if (e < SHADE_E_LVL1) begin
            lvl = 2'd0;
        end else if (e < SHADE_E_LVL2) begin
            lvl = 2'd1;
        end else if (e < SHADE_E_LVL3) begin
            lvl = 2'd2;
        end else begin
            lvl = 2'd3;
        end
        return {c[11:8] >> lvl, c[7:4] >> lvl, c[3:0] >> lvl};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
// First-word-fall-through FIFO. The head entry is visible on data_o
// whenever empty_o is low; a pop advances to the next entry.
// Occupancy is kept in an explicit counter so full/empty never depend on
// pointer comparison. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is ignored (caller flags it).
// Ports:
//   clk_i, rst_n_i      - clock, asynchronous active-low reset
//   push_i, data_i      - write request and data
//   pop_i               - remove head (ignored when empty)
//   data_o              - head entry
//   full_o, empty_o     - status
//   count_o             - occupancy, 0..DEPTH
module pixel_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_s = (count_q == {(AW+1){1'b0}});
    assign full_s  = (count_q == FULL_COUNT);

    // Next-state for pointers and occupancy; a full FIFO takes a push only
    // when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop_i && !empty_s;
        do_push_s = push_i && (!full_s || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so
    // it carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = count_q;

endmodule

// File: rtl/pixel_writeback.sv
// pixel_writeback
// Turns per-pixel intersection results into framebuffer writes.
// Stage 1 registers the range-checked result as {linear address, colour};
// stage 2 pushes it into a FWFT FIFO whose head drives the write port.
// Upstream cannot be stalled, so a push into a full FIFO with no pop is
// dropped and recorded in the sticky overflow flag.
// Optional build macro: PIXEL_DEPTH_SHADE_EN - dims hit colours by the
// exponent of best_t_in; without it best_t_in is ignored.
// Ports:
//   clk_in, rst_n_in            - clock, asynchronous active-low reset
//   x_in, y_in                  - pixel coordinate
//   best_block_in, best_t_in    - nearest block (15 = miss), hit distance
//   valid_in                    - qualifies the result inputs
//   fb_addr_out, fb_data_out    - write address (y*H_RES+x) and RGB444
//   fb_valid_out, fb_ready_in   - write handshake
//   overflow_out                - sticky drop flag
//   count_out                   - FIFO occupancy
//   frame_done_out              - pulse after last pixel of frame written
module pixel_writeback
    import pixel_pkg::*;
#(
    parameter int H_RES = 1280,
    parameter int V_RES = 720,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [10:0]              x_in,
    input  logic [9:0]               y_in,
    input  logic [3:0]               best_block_in,
    input  logic [31:0]              best_t_in,
    input  logic                     valid_in,
    output logic [19:0]              fb_addr_out,
    output logic [11:0]              fb_data_out,
    output logic                     fb_valid_out,
    input  logic                     fb_ready_in,
    output logic                     overflow_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     frame_done_out
);

    localparam logic [11:0] X_LIMIT   = 12'(H_RES);
    localparam logic [10:0] Y_LIMIT   = 11'(V_RES);
    localparam logic [19:0] LAST_ADDR = 20'(H_RES * V_RES - 1);

    logic                   in_range_s;
    logic [19:0]            addr_s;
    rgb444_t                color_s;
    fb_entry_t              entry_d;
    fb_entry_t              s1_entry_q;
    logic                   s1_valid_q;
    fb_entry_t              head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic                   head_valid_s;
    logic                   pop_s;
    logic                   overflow_q;
    logic                   overflow_d;
    logic                   frame_done_q;
    logic                   frame_done_d;
    logic                   unused_best_t_s;

    // Out-of-range coordinates are dropped silently before stage 1.
    assign in_range_s = valid_in
                        && ({1'b0, x_in} < X_LIMIT)
                        && ({1'b0, y_in} < Y_LIMIT);

    generate
        if (H_RES == 1280) begin : g_addr_shift
            // y*1280 = y*1024 + y*256, kept out of DSP blocks.
            assign addr_s = {y_in, 10'b0} + {2'b0, y_in, 8'b0} + {9'b0, x_in};
        end else begin : g_addr_mul
            assign addr_s = ({10'b0, y_in} * 20'(H_RES)) + {9'b0, x_in};
        end
    endgenerate

`ifdef PIXEL_DEPTH_SHADE_EN
    assign unused_best_t_s = ^{best_t_in[31], best_t_in[22:0]};

    // Palette lookup with depth dimming; the background is never dimmed.
    always_comb begin
        color_s = PALETTE[best_block_in];
        if (best_block_in != MISS_BLOCK) begin
            color_s = shade_color(PALETTE[best_block_in], best_t_in[30:23]);
        end else begin
            color_s = PALETTE[best_block_in];
        end
    end
`else
    assign unused_best_t_s = ^best_t_in;

    // Plain palette lookup.
    always_comb begin
        color_s = PALETTE[best_block_in];
    end
`endif

    assign entry_d = '{addr: addr_s, data: color_s};

    // Stage 1 register: captures in-range results only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
        end else begin
            s1_valid_q <= in_range_s;
            if (in_range_s) begin
                s1_entry_q <= entry_d;
            end
        end
    end

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .push_i  (s1_valid_q),
        .data_i  (s1_entry_q),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign head_valid_s = !fifo_empty_s;
    assign pop_s        = head_valid_s && fb_ready_in;

    // Overflow is sticky; frame_done marks a handshake on the final pixel.
    always_comb begin
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        if (s1_valid_q && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        if (pop_s && (head_s.addr == LAST_ADDR)) begin
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // Status flag registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Head is masked while empty so the port reads zero after reset even
    // though the storage array itself is not cleared.
    assign fb_addr_out    = head_valid_s ? head_s.addr : 20'd0;
    assign fb_data_out    = head_valid_s ? head_s.data : 12'd0;
    assign fb_valid_out   = head_valid_s;
    assign overflow_out   = overflow_q;
    assign count_out      = fifo_count_s;
    assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_pixel_writeback.sv
module tb_pixel_writeback;

    localparam int H_RES = 1280;
    localparam int V_RES = 720;
    localparam int DEPTH = 16;
    localparam int LAST  = H_RES * V_RES - 1;

    localparam logic [11:0] PAL [16] = '{
        12'hF00, 12'h0F0, 12'hFFF, 12'h00F,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h888,
        12'hF80, 12'h8F0, 12'h08F, 12'hF08,
        12'h80F, 12'h0F8, 12'h444, 12'h123
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  blk;
    logic [31:0] t;
    logic        valid;
    logic        ready;
    logic [19:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_valid;
    logic        overflow;
    logic [4:0]  count;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pixel_writeback #(.H_RES(H_RES), .V_RES(V_RES), .DEPTH(DEPTH)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .x_in           (x),
        .y_in           (y),
        .best_block_in  (blk),
        .best_t_in      (t),
        .valid_in       (valid),
        .fb_addr_out    (fb_addr),
        .fb_data_out    (fb_data),
        .fb_valid_out   (fb_valid),
        .fb_ready_in    (ready),
        .overflow_out   (overflow),
        .count_out      (count),
        .frame_done_out (frame_done)
    );

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    bit          pipe_valid;
    logic [31:0] pipe_entry;
    bit          m_ovf;
    bit          m_fd;

    function automatic logic [11:0] model_color(input logic [3:0] b, input logic [31:0] tt);
        logic [11:0] c;
`ifdef PIXEL_DEPTH_SHADE_EN
        int e;
        int lvl;
`endif
        c = PAL[b];
`ifdef PIXEL_DEPTH_SHADE_EN
        e = int'(tt[30:23]);
        lvl = (e < 130) ? 0 : (e < 131) ? 1 : (e < 132) ? 2 : 3;
        if (b != 4'd15) begin
            c = {4'(int'(c[11:8]) / (1 << lvl)),
                 4'(int'(c[7:4]) / (1 << lvl)),
                 4'(int'(c[3:0]) / (1 << lvl))};
        end
`else
        if (tt === 32'hx) c = 12'h000;
`endif
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        pipe_valid = 0;
        m_ovf = 0;
        m_fd = 0;
    endtask

    // One clock edge of the intended behaviour, using pre-edge inputs.
    task automatic model_update();
        bit popped;
        int addr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        popped = (mq.size() > 0) && ready;
        m_fd = 0;
        if (popped) begin
            if (int'(mq[0][31:12]) == LAST) m_fd = 1;
            void'(mq.pop_front());
        end
        if (pipe_valid) begin
            if (mq.size() < DEPTH) mq.push_back(pipe_entry);
            else m_ovf = 1;
        end
        pipe_valid = valid && (int'(x) < H_RES) && (int'(y) < V_RES);
        if (pipe_valid) begin
            addr = int'(y) * H_RES + int'(x);
            pipe_entry = {20'(addr), model_color(blk, t)};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_outputs();
        chk("fb_valid", 32'(fb_valid), 32'(mq.size() > 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (mq.size() > 0) begin
            chk("head_addr", 32'(fb_addr), 32'(mq[0][31:12]));
            chk("head_data", 32'(fb_data), 32'(mq[0][11:0]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        compare_outputs();
    endtask

    task automatic drive(input bit v, input int xx, input int yy,
                         input logic [3:0] b, input logic [31:0] tt);
        valid = v;
        x = 11'(xx);
        y = 10'(yy);
        blk = b;
        t = tt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 4'd0, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [3:0]  blk;
        logic [31:0] t;
        logic        exp_valid;
        logic [19:0] exp_addr;
        logic [11:0] exp_data;
    } vec_t;

    localparam logic [31:0] T20 = 32'h41A0_0000;
    localparam logic [31:0] T4  = 32'h4080_0000;

    vec_t vecs[9];
    logic [19:0] got[$];

    initial begin
`ifdef PIXEL_DEPTH_SHADE_EN
        logic [11:0] far_exp = 12'h333;
`else
        logic [11:0] far_exp = 12'hFFF;
`endif
        vecs[0] = '{3,    2,   4'd1,  T4,  1'b1, 20'd2563,   12'h0F0};
        vecs[1] = '{1279, 719, 4'd15, T20, 1'b1, 20'd921599, 12'h123};
        vecs[2] = '{1280, 0,   4'd3,  T4,  1'b0, 20'd0,      12'h000};
        vecs[3] = '{0,    720, 4'd3,  T4,  1'b0, 20'd0,      12'h000};
        vecs[4] = '{0,    0,   4'd0,  T4,  1'b1, 20'd0,      12'hF00};
        vecs[5] = '{1279, 0,   4'd4,  T4,  1'b1, 20'd1279,   12'hFF0};
        vecs[6] = '{0,    719, 4'd7,  T4,  1'b1, 20'd920320, 12'h888};
        vecs[7] = '{5,    5,   4'd2,  T20, 1'b1, 20'd6405,   far_exp};
        vecs[8] = '{5,    5,   4'd2,  T4,  1'b1, 20'd6405,   12'hFFF};

        model_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        drive(0, 0, 0, 4'd0, 32'd0);
        cycle();
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Table: single results with a ready sink, checked at latency 2.
        ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1, vecs[i].x, vecs[i].y, vecs[i].blk, vecs[i].t);
            cycle();
            drive(0, 0, 0, 4'd0, 32'd0);
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(fb_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vecs[i].exp_data));
            end
            cycle();
            chk($sformatf("vec%0d_fd", i), 32'(frame_done),
                32'(vecs[i].exp_valid && vecs[i].exp_addr == 20'(LAST)));
            chk($sformatf("vec%0d_cnt0", i), 32'(count), 32'd0);
            cycle();
            chk($sformatf("vec%0d_fd_once", i), 32'(frame_done), 32'd0);
        end

        // Stalled sink, 20 results: saturate, overflow, first 16 drain in order.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 3, 4'(i), T4);
            cycle();
        end
        drive(0, 0, 0, 4'd0, 32'd0);
        cycle();
        cycle();
        chk("sat_count", 32'(count), 32'd16);
        chk("sat_overflow", 32'(overflow), 32'd1);
        ready = 1'b1;
        got.delete();
        for (int k = 0; k < 20; k++) begin
            if (fb_valid) got.push_back(fb_addr);
            cycle();
        end
        chk("drain_len", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("drain%0d", i), 32'(got[i]), 32'(3 * H_RES + i));

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            ready = (i >= 17);
            drive(1, i, 9, 4'(i), T4);
            cycle();
            if (i >= 17) begin
                chk("fullpp_count", 32'(count), 32'd16);
                chk("fullpp_ovf", 32'(overflow), 32'd0);
            end
        end
        drive(0, 0, 0, 4'd0, 32'd0);
        for (int i = 0; i < 20; i++) cycle();

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int xx;
            int yy;
            xx = $urandom_range(0, 1300);
            yy = $urandom_range(0, 730);
            if ($urandom_range(0, 19) == 0) begin
                xx = 1279;
                yy = 719;
            end
            drive(($urandom_range(0, 3) != 0), xx, yy, 4'($urandom_range(0, 15)),
                  {1'b0, 8'($urandom_range(126, 135)), 23'($urandom)});
            ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drive(0, 0, 0, 4'd0, 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();

        // Asynchronous reset with entries queued.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 100 + i, 50, 4'(i), T4);
            cycle();
        end
        drive(0, 0, 0, 4'd0, 32'd0);
        cycle();
        cycle();
        chk("pre_rst_count", 32'(count), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(fb_valid), 32'd0);
        chk("arst_addr", 32'(fb_addr), 32'd0);
        chk("arst_data", 32'(fb_data), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_valid", 32'(fb_valid), 32'd0);
            chk("post_rst_count", 32'(count), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
